// File: rtl/game_fsm.sv
// Game sequencing controller: key synchronizers, frame tick, collision flags,
// START/RUN/PAUSED/CRASH/FINISH state machine and the elapsed-seconds timer.
module game_fsm #(
    parameter int FRAME_Y        = 481,
    parameter int GRACE_FRAMES   = 30,
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enter_key,
    input  logic       pause_key,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       car_on,
    input  logic       road_on,
    input  logic       finish_line,
    output logic       game_reset,
    output logic       pause,
    output logic       start_en,
    output logic       crash_en,
    output logic       finish_en,
    output logic [7:0] elapsed_sec
);

    // state    | meaning
    // START    | title screen, road and car held at start positions
    // RUN      | race in progress, timer counting
    // PAUSED   | motion frozen by the pause key
    // CRASH    | car left the road, crash screen shown
    // FINISH   | car reached the finish line, finish screen shown
    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_RUN    = 3'd1,
        ST_PAUSED = 3'd2,
        ST_CRASH  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam int GW = (GRACE_FRAMES   < 2) ? 1 : $clog2(GRACE_FRAMES + 1);
    localparam int FW = (FRAMES_PER_SEC < 2) ? 1 : $clog2(FRAMES_PER_SEC);

    state_t        state;
    logic [GW-1:0] grace_cnt;
    logic [FW-1:0] frame_cnt;

    logic enter_s1, enter_s2, enter_s3, enter_ev;
    logic pause_s1, pause_s2, pause_s3, pause_ev;
    logic [1:0] arm_cnt;
    logic       arm;
    logic at_frame, at_frame_d, frame_tick;
    logic crash_seen, finish_seen;

    // {game_reset, start_en, pause, crash_en, finish_en}
    function automatic logic [4:0] decode(input state_t s);
        case (s)
            ST_START:  decode = 5'b11000;
            ST_PAUSED: decode = 5'b00100;
            ST_CRASH:  decode = 5'b00110;
            ST_FINISH: decode = 5'b00101;
            default:   decode = 5'b00000;
        endcase
    endfunction

    // Edge detection stays disarmed until the third stage holds a real key
    // sample, so a key held through reset release never looks like a press.
    assign arm = (arm_cnt == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {enter_s1, enter_s2, enter_s3, enter_ev} <= 4'b0;
            {pause_s1, pause_s2, pause_s3, pause_ev} <= 4'b0;
            arm_cnt <= 2'd0;
        end else begin
            enter_s1 <= enter_key;
            enter_s2 <= enter_s1;
            enter_s3 <= enter_s2;
            enter_ev <= arm & enter_s2 & ~enter_s3;
            pause_s1 <= pause_key;
            pause_s2 <= pause_s1;
            pause_s3 <= pause_s2;
            pause_ev <= arm & pause_s2 & ~pause_s3;
            if (!arm) arm_cnt <= arm_cnt + 2'd1;
        end
    end

    assign at_frame   = (pixel_y == 10'(FRAME_Y)) && (pixel_x == 10'd0);
    assign frame_tick = at_frame & ~at_frame_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            at_frame_d  <= 1'b0;
            crash_seen  <= 1'b0;
            finish_seen <= 1'b0;
        end else begin
            at_frame_d <= at_frame;
            // Clearing wins on the tick clk, dropping anything seen on it.
            if (state != ST_RUN || frame_tick) begin
                crash_seen  <= 1'b0;
                finish_seen <= 1'b0;
            end else begin
                if (video_on && car_on && !road_on)   crash_seen  <= 1'b1;
                if (video_on && car_on && finish_line) finish_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_START;
            {game_reset, start_en, pause, crash_en, finish_en} <= decode(ST_START);
            grace_cnt   <= '0;
            frame_cnt   <= '0;
            elapsed_sec <= 8'd0;
        end else begin
            case (state)
                ST_START: begin
                    if (enter_ev) begin
                        state       <= ST_RUN;
                        {game_reset, start_en, pause, crash_en, finish_en} <= decode(ST_RUN);
                        grace_cnt   <= GW'(GRACE_FRAMES);
                        frame_cnt   <= '0;
                        elapsed_sec <= 8'd0;
                    end
                end
                ST_RUN: begin
                    if (pause_ev) begin
                        state <= ST_PAUSED;
                        {game_reset, start_en, pause, crash_en, finish_en} <= decode(ST_PAUSED);
                    end else if (frame_tick) begin
                        if (frame_cnt == FW'(FRAMES_PER_SEC - 1)) begin
                            frame_cnt <= '0;
                            if (elapsed_sec != 8'hFF) elapsed_sec <= elapsed_sec + 8'd1;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                        if (grace_cnt != '0) begin
                            grace_cnt <= grace_cnt - 1'b1;
                        end else if (finish_seen) begin
                            state <= ST_FINISH;
                            {game_reset, start_en, pause, crash_en, finish_en} <= decode(ST_FINISH);
                        end else if (crash_seen) begin
                            state <= ST_CRASH;
                            {game_reset, start_en, pause, crash_en, finish_en} <= decode(ST_CRASH);
                        end
                    end
                end
                ST_PAUSED: begin
                    if (pause_ev) begin
                        state <= ST_RUN;
                        {game_reset, start_en, pause, crash_en, finish_en} <= decode(ST_RUN);
                    end
                end
                ST_CRASH, ST_FINISH: begin
                    if (enter_ev) begin
                        state       <= ST_START;
                        {game_reset, start_en, pause, crash_en, finish_en} <= decode(ST_START);
                        frame_cnt   <= '0;
                        elapsed_sec <= 8'd0;
                    end
                end
                default: begin
                    state <= ST_START;
                    {game_reset, start_en, pause, crash_en, finish_en} <= decode(ST_START);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm: start latency, grace period, finish priority,
// pause/timer hold, saturation and reset behaviour.
module tb_game_fsm;

    localparam int FRAME_Y = 481;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enter_key = 1'b0;
    logic       pause_key = 1'b0;
    logic [9:0] pixel_x = 10'd0;
    logic [9:0] pixel_y = 10'd0;
    logic       video_on = 1'b0;
    logic       car_on = 1'b0;
    logic       road_on = 1'b1;
    logic       finish_line = 1'b0;
    logic       game_reset, pause, start_en, crash_en, finish_en;
    logic [7:0] elapsed_sec;

    int n_vec = 0;
    int n_err = 0;

    game_fsm #(.FRAME_Y(FRAME_Y), .GRACE_FRAMES(30), .FRAMES_PER_SEC(60)) dut (
        .clk(clk), .reset_n(reset_n),
        .enter_key(enter_key), .pause_key(pause_key),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .car_on(car_on), .road_on(road_on), .finish_line(finish_line),
        .game_reset(game_reset), .pause(pause), .start_en(start_en),
        .crash_en(crash_en), .finish_en(finish_en), .elapsed_sec(elapsed_sec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // {game_reset, start_en, pause, crash_en, finish_en}
    function automatic int outs();
        return int'({game_reset, start_en, pause, crash_en, finish_en});
    endfunction

    // One frame: one clk off the frame row, then two clks on it (single tick).
    task automatic frame();
        @(negedge clk); pixel_y = 10'd0;
        @(negedge clk); pixel_y = 10'(FRAME_Y); pixel_x = 10'd0;
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic press_enter();
        @(negedge clk); enter_key = 1'b1;
        repeat (5) @(negedge clk);
        enter_key = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_pause();
        @(negedge clk); pause_key = 1'b1;
        repeat (5) @(negedge clk);
        pause_key = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // reset values
        #12;
        chk("reset_outs", outs(), 5'b11000);
        chk("reset_elapsed", elapsed_sec, 0);
        @(negedge clk); reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // enter event lands 3 clk after the key edge
        enter_key = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("start_before_3clk", outs(), 5'b11000);
        @(posedge clk);
        #1 chk("run_at_3clk", outs(), 5'b00000);
        @(negedge clk); enter_key = 1'b0;
        repeat (4) @(negedge clk);

        // crash ignored during 30 grace frames, taken on tick 31
        video_on = 1'b1; car_on = 1'b1; road_on = 1'b0;
        frames(30);
        chk("grace_no_crash", outs(), 5'b00000);
        frame();
        chk("crash_tick31", outs(), 5'b00110);
        car_on = 1'b0; road_on = 1'b1;
        press_pause();
        chk("crash_ignores_pause", outs(), 5'b00110);
        press_enter();
        chk("crash_to_start", outs(), 5'b11000);
        chk("start_elapsed_clear", elapsed_sec, 0);

        // collision only on the tick clk is dropped
        press_enter();
        frames(30);
        @(negedge clk); pixel_y = 10'd0;
        @(negedge clk); pixel_y = 10'(FRAME_Y); car_on = 1'b1; road_on = 1'b0;
        @(negedge clk); car_on = 1'b0; road_on = 1'b1;
        frame();
        chk("tick_clk_flag_dropped", outs(), 5'b00000);

        // finish wins over crash in the same frame
        car_on = 1'b1; road_on = 1'b0; finish_line = 1'b1;
        frame();
        chk("finish_priority", outs(), 5'b00101);
        car_on = 1'b0; road_on = 1'b1; finish_line = 1'b0;
        press_enter();
        chk("finish_to_start", outs(), 5'b11000);

        // timer: 125 run, 200 paused, 60 run
        press_enter();
        chk("run_elapsed0", elapsed_sec, 0);
        frames(125);
        chk("elapsed_125f", elapsed_sec, 2);
        press_pause();
        chk("paused_outs", outs(), 5'b00100);
        press_enter();
        chk("paused_ignores_enter", outs(), 5'b00100);
        frames(200);
        chk("elapsed_paused_hold", elapsed_sec, 2);
        press_pause();
        chk("resume_outs", outs(), 5'b00000);
        frames(60);
        chk("elapsed_185f", elapsed_sec, 3);

        // saturation: 185 + 15400 frames is well past 255 s
        frames(15400);
        chk("elapsed_saturated", elapsed_sec, 255);
        frames(100);
        chk("elapsed_sat_held", elapsed_sec, 255);
        car_on = 1'b1; road_on = 1'b0;
        frame();
        chk("sat_crash", outs(), 5'b00110);
        chk("crash_elapsed_hold", elapsed_sec, 255);
        car_on = 1'b0; road_on = 1'b1;
        press_enter();
        chk("sat_restart_outs", outs(), 5'b11000);
        chk("sat_restart_elapsed", elapsed_sec, 0);

        // mid-frame reset in RUN with enter held across release
        press_enter();
        frames(3);
        chk("pre_reset_run", outs(), 5'b00000);
        chk("pre_reset_elapsed", elapsed_sec, 0);
        @(negedge clk); pixel_y = 10'd100; enter_key = 1'b1;
        #1 reset_n = 1'b0;
        #1 chk("async_reset_outs", outs(), 5'b11000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_enter_no_event", outs(), 5'b11000);
        enter_key = 1'b0;
        repeat (4) @(negedge clk);
        press_enter();
        chk("post_reset_start", outs(), 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_fsm.md
GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 The block SHALL have parameter FRAME_Y, default 481: the pixel_y row that marks end-of-frame.
REQ-002 The block SHALL have parameter GRACE_FRAMES, default 30: the number of frames after start during which collisions are ignored.
REQ-003 The block SHALL have parameter FRAMES_PER_SEC, default 60: the number of frame ticks per elapsed-time second.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock (100 MHz); all logic is synchronous to it.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports enter_key and pause_key, inputs, 1 bit each: raw, asynchronous, already-debounced buttons.
REQ-007 The block SHALL have ports pixel_x and pixel_y, inputs, 10 bits each: current scan position.
REQ-008 The block SHALL have port video_on, input, 1 bit: visible-area flag.
REQ-009 The block SHALL have ports car_on, road_on and finish_line, inputs, 1 bit each: per-pixel object flags from the graphics stage.
REQ-010 The block SHALL have port game_reset, output, 1 bit: holds the road and car at their start positions.
REQ-011 The block SHALL have port pause, output, 1 bit: freezes motion in the graphics stage.
REQ-012 The block SHALL have ports start_en, crash_en and finish_en, outputs, 1 bit each: text-screen selects.
REQ-013 The block SHALL have port elapsed_sec, output, 8 bits: race time in seconds.

Function
REQ-014 The block SHALL pass enter_key and pause_key each through a 2-flop synchronizer followed by a rising-edge detector, giving a 1-clk event 3 clk after the input edge.
REQ-015 The block SHALL generate frame_tick, a 1-clk pulse on the first clk where (pixel_y==FRAME_Y && pixel_x==0) becomes true, with at most one pulse per frame.
REQ-016 The block SHALL set sticky flag crash_seen on any clk with video_on && car_on && !road_on, and sticky flag finish_seen on any clk with video_on && car_on && finish_line.
REQ-017 The block SHALL evaluate both flags on the frame_tick clk and clear them on the same clk, so that a flag set on the tick clk itself is discarded.
REQ-018 The block SHALL implement a state machine with states START, RUN, PAUSED, CRASH and FINISH, encoded in a 3-bit register.
REQ-019 In START, an enter event SHALL move the state to RUN, load grace_cnt=GRACE_FRAMES and clear the timer.
REQ-020 In RUN, a pause event SHALL move the state to PAUSED with top priority.
REQ-021 In RUN, on frame_tick with grace_cnt==0, finish_seen SHALL move the state to FINISH; otherwise crash_seen SHALL move it to CRASH, with finish taking priority when both are set.
REQ-022 In RUN, on frame_tick with grace_cnt>0, the block SHALL decrement grace_cnt and ignore both flags.
REQ-023 In PAUSED, a pause event SHALL return the state to RUN with grace_cnt and timer unchanged, and enter events SHALL be ignored.
REQ-024 In CRASH and FINISH, an enter event SHALL move the state to START, and pause events SHALL be ignored.
REQ-025 Outputs SHALL be a Moore decode of the state register only: game_reset=start_en=1 in START; pause=1 in PAUSED, CRASH and FINISH; crash_en=1 only in CRASH; finish_en=1 only in FINISH; all others 0.
REQ-026 In RUN, frame_tick SHALL increment frame_cnt (0..FRAMES_PER_SEC-1), and when frame_cnt wraps, elapsed_sec SHALL increment, saturating at 255.
REQ-027 The timer SHALL hold its value in PAUSED, CRASH and FINISH, and SHALL clear on entry to START.
REQ-028 Outside RUN, the block SHALL hold crash_seen and finish_seen at 0.

Reset
REQ-029 When reset_n is low, the block SHALL asynchronously set state=START, game_reset=1, start_en=1, pause=crash_en=finish_en=0, elapsed_sec=0, frame_cnt=0, grace_cnt=0, both flags=0 and all synchronizer/edge flops=0.
REQ-030 When reset_n is asserted in any state, the block SHALL return to START immediately, and a key held high through reset release SHALL NOT produce an event.

Verification
REQ-031 Verification SHALL cover start: reset release, then an enter pulse -> RUN with game_reset=0 and start_en=0, 3 clk after the edge.
REQ-032 Verification SHALL cover the crash grace period: in RUN, drive car_on=1 and road_on=0 each frame -> no CRASH during the first 30 frame ticks, then CRASH on tick 31 with crash_en=1 and pause=1.
REQ-033 Verification SHALL cover simultaneous finish and crash: after the grace period, set both conditions in one frame -> FINISH with finish_en=1 and crash_en=0.
REQ-034 Verification SHALL cover pause and the timer: run 125 frames, pause for 200 frames, resume and run 60 frames -> elapsed_sec=3, with no change while paused.
REQ-035 Verification SHALL cover saturation and restart: run more than 256 s of frames -> elapsed_sec=255 and held; then crash and press enter -> START with elapsed_sec=0.
REQ-036 Verification SHALL cover mid-run reset: assert reset_n=0 mid-frame in RUN -> outputs at reset values within the same clk, and no event when enter is held across reset release.
